// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX read-side drain controller.
package uart_pkg;

  localparam int unsigned UART_RX_DRAIN_CNT_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapt,
    StHold,
    StFlush
  } rx_drain_state_e;

endpackage

// File: rtl/uart_rx_timeout_timer.sv
// Saturating idle-cycle counter. Emits a single-cycle hit once the count has sat
// at TIMEOUT_CYCLES-1 for one enabled cycle; any clr or a dropped en restarts it.
module uart_rx_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt;
  logic            fired;

  // Fire once per idle stretch so the hit stays a pulse while saturated.
  assign hit = en & ~clr & ~fired & (cnt == CntMax);

  // Count enabled cycles, saturating at CntMax.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt   <= '0;
      fired <= 1'b0;
    end else begin
      if (cnt != CntMax) cnt <= cnt + CntW'(1);
      if (hit) fired <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_drain_ctrl.sv
// UART RX read-side drain controller: prefetches one byte from the RX FIFO into
// the RBR, reports data-ready, raises avail/timeout interrupts and sequences
// software flushes. Optional feature macro: UART_RX_DRAIN_STATS_EN enables the
// delivered-byte counter; without it rx_byte_count is tied to zero.
module uart_rx_drain_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned FLUSH_CYCLES   = 4
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  output logic                           fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
  input  logic                           fifo_rd_empty,
  output logic                           fifo_clear,
  input  logic                           reg_rd_req,
  output logic [DATA_WIDTH-1:0]          reg_rd_data,
  output logic                           data_ready,
  input  logic                           flush_req,
  output logic                           flush_busy,
  input  logic                           ien_avail,
  input  logic                           ien_timeout,
  output logic                           timeout_flag,
  output logic                           irq,
  output logic [UART_RX_DRAIN_CNT_W-1:0] rx_byte_count
);

  localparam int unsigned FlushCntW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(FLUSH_CYCLES - 1);

  rx_drain_state_e      state;
  logic [FlushCntW-1:0] flush_cnt;
  logic                 tmo_clr;
  logic                 tmo_en;
  logic                 tmo_hit;

  // FIFO strobes come straight from registered state: no input-to-output path.
  assign fifo_rd_en = (state == StFetch);
  assign fifo_clear = (state == StFlush);
  assign flush_busy = (state == StFlush);

  // Idle counting only while a byte is held, the FIFO is dry and nothing reads it.
  assign tmo_clr = (state == StCapt) | flush_req;
  assign tmo_en  = (state == StHold) & fifo_rd_empty & ~reg_rd_req & ~flush_req;

  uart_rx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk(rd_clk),
    .rst(rd_rst),
    .clr(tmo_clr),
    .en (tmo_en),
    .hit(tmo_hit)
  );

  // Drain FSM with registered holding register and status flags.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state        <= StIdle;
      flush_cnt    <= '0;
      reg_rd_data  <= '0;
      data_ready   <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (flush_req) begin
      // Flush overrides everything, including a same-cycle RBR read.
      state        <= StFlush;
      flush_cnt    <= '0;
      data_ready   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (!fifo_rd_empty) state <= StFetch;
        end
        StFetch: state <= StCapt;
        StCapt: begin
          reg_rd_data <= fifo_rd_data;
          data_ready  <= 1'b1;
          state       <= StHold;
        end
        StHold: begin
          if (reg_rd_req) begin
            data_ready   <= 1'b0;
            timeout_flag <= 1'b0;
            state        <= fifo_rd_empty ? StIdle : StFetch;
          end else if (tmo_hit) begin
            timeout_flag <= 1'b1;
          end
        end
        StFlush: begin
          if (flush_cnt == FlushLast) begin
            state <= StIdle;
          end else begin
            flush_cnt <= flush_cnt + FlushCntW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Interrupt is a registered OR of the enabled sources.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) irq <= 1'b0;
    else        irq <= (ien_avail & data_ready) | (ien_timeout & timeout_flag);
  end

`ifdef UART_RX_DRAIN_STATS_EN
  logic rd_accept;

  // Only HOLD holds valid data, so a read there is a delivered byte.
  assign rd_accept = (state == StHold) & reg_rd_req & ~flush_req;

  // Wrapping delivered-byte counter; flushes leave it alone.
  always_ff @(posedge rd_clk) begin
    if (rd_rst)         rx_byte_count <= '0;
    else if (rd_accept) rx_byte_count <= rx_byte_count + UART_RX_DRAIN_CNT_W'(1);
  end
`else
  assign rx_byte_count = '0;
`endif

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Directed self-checking bench for uart_rx_drain_ctrl (TIMEOUT_CYCLES=16, FLUSH_CYCLES=4).
module tb_uart_rx_drain_ctrl;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_empty;
  logic        fifo_clear;
  logic        reg_rd_req = 1'b0;
  logic [7:0]  reg_rd_data;
  logic        data_ready;
  logic        flush_req = 1'b0;
  logic        flush_busy;
  logic        ien_avail = 1'b0;
  logic        ien_timeout = 1'b0;
  logic        timeout_flag;
  logic        irq;
  logic [15:0] rx_byte_count;

  int checks = 0;
  int errors = 0;

  // Simple FIFO model: bench writes mem/wr_ptr, the pop process owns rd_ptr.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_en_pulses = 0;

  assign fifo_rd_empty = (rd_ptr == wr_ptr);

  always #5 rd_clk = ~rd_clk;

  uart_rx_drain_ctrl #(
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(16),
    .FLUSH_CYCLES(4)
  ) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_clear(fifo_clear),
    .reg_rd_req(reg_rd_req),
    .reg_rd_data(reg_rd_data),
    .data_ready(data_ready),
    .flush_req(flush_req),
    .flush_busy(flush_busy),
    .ien_avail(ien_avail),
    .ien_timeout(ien_timeout),
    .timeout_flag(timeout_flag),
    .irq(irq),
    .rx_byte_count(rx_byte_count)
  );

  always @(posedge rd_clk) begin
    if (fifo_rd_en) rd_en_pulses <= rd_en_pulses + 1;
    if (fifo_clear) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  function automatic int exp_cnt(input int n);
`ifdef UART_RX_DRAIN_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!data_ready && n < 12) begin
      cyc();
      n++;
    end
    check_eq(tag, {31'd0, data_ready}, 32'd1);
  endtask

  task automatic rd_rbr();
    reg_rd_req = 1'b1;
    cyc();
    reg_rd_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    check_eq({pfx, "_clear"}, {31'd0, fifo_clear}, 32'd0);
    check_eq({pfx, "_rbr"}, {24'd0, reg_rd_data}, 32'd0);
    check_eq({pfx, "_dr"}, {31'd0, data_ready}, 32'd0);
    check_eq({pfx, "_busy"}, {31'd0, flush_busy}, 32'd0);
    check_eq({pfx, "_tmo"}, {31'd0, timeout_flag}, 32'd0);
    check_eq({pfx, "_irq"}, {31'd0, irq}, 32'd0);
    check_eq({pfx, "_cnt"}, {16'd0, rx_byte_count}, 32'd0);
  endtask

  initial begin
    int base;
    logic [7:0] exp_b [0:2];
    exp_b[0] = 8'h11;
    exp_b[1] = 8'h22;
    exp_b[2] = 8'h33;

    // Reset
    cyc();
    cyc();
    check_reset_vals("rst");
    rd_rst = 1'b0;
    cyc();

    // Single byte: pop, 3-cycle latency, irq one cycle later
    ien_avail = 1'b1;
    base = rd_en_pulses;
    push(8'hA5);
    cyc();
    check_eq("t1_rd_en_hi", {31'd0, fifo_rd_en}, 32'd1);
    cyc();
    check_eq("t1_rd_en_lo", {31'd0, fifo_rd_en}, 32'd0);
    check_eq("t1_dr_early", {31'd0, data_ready}, 32'd0);
    cyc();
    check_eq("t1_dr", {31'd0, data_ready}, 32'd1);
    check_eq("t1_rbr", {24'd0, reg_rd_data}, 32'hA5);
    check_eq("t1_irq_lag", {31'd0, irq}, 32'd0);
    cyc();
    check_eq("t1_irq", {31'd0, irq}, 32'd1);
    check_eq("t1_pulses", rd_en_pulses - base, 32'd1);
    rd_rbr();
    check_eq("t1_dr_clr", {31'd0, data_ready}, 32'd0);
    check_eq("t1_cnt", {16'd0, rx_byte_count}, exp_cnt(1));
    cyc();
    check_eq("t1_irq_clr", {31'd0, irq}, 32'd0);

    // Three queued bytes, each read as soon as it is ready
    base = rd_en_pulses;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    for (int i = 0; i < 3; i++) begin
      wait_ready($sformatf("t2_ready%0d", i));
      check_eq($sformatf("t2_rbr%0d", i), {24'd0, reg_rd_data}, {24'd0, exp_b[i]});
      rd_rbr();
    end
    cyc();
    cyc();
    cyc();
    check_eq("t2_pulses", rd_en_pulses - base, 32'd3);
    check_eq("t2_cnt", {16'd0, rx_byte_count}, exp_cnt(4));
    check_eq("t2_dr_idle", {31'd0, data_ready}, 32'd0);

    // Character timeout at exactly 16 cycles after HOLD entry
    ien_avail = 1'b0;
    ien_timeout = 1'b1;
    push(8'h5A);
    wait_ready("t3_ready");
    for (int i = 0; i < 15; i++) cyc();
    check_eq("t3_tmo_15", {31'd0, timeout_flag}, 32'd0);
    cyc();
    check_eq("t3_tmo_16", {31'd0, timeout_flag}, 32'd1);
    check_eq("t3_irq_lag", {31'd0, irq}, 32'd0);
    cyc();
    check_eq("t3_irq", {31'd0, irq}, 32'd1);
    check_eq("t3_tmo_sticky", {31'd0, timeout_flag}, 32'd1);
    rd_rbr();
    check_eq("t3_tmo_clr", {31'd0, timeout_flag}, 32'd0);
    check_eq("t3_dr_clr", {31'd0, data_ready}, 32'd0);
    cyc();
    check_eq("t3_irq_clr", {31'd0, irq}, 32'd0);
    ien_timeout = 1'b0;

    // Flush in the FETCH cycle: popped byte discarded
    base = rd_en_pulses;
    push(8'h77);
    cyc();
    check_eq("t4_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t4_clear%0d", i), {31'd0, fifo_clear}, 32'd1);
      check_eq($sformatf("t4_busy%0d", i), {31'd0, flush_busy}, 32'd1);
      check_eq($sformatf("t4_dr%0d", i), {31'd0, data_ready}, 32'd0);
      cyc();
    end
    check_eq("t4_clear_end", {31'd0, fifo_clear}, 32'd0);
    check_eq("t4_busy_end", {31'd0, flush_busy}, 32'd0);
    cyc();
    cyc();
    cyc();
    check_eq("t4_dr_after", {31'd0, data_ready}, 32'd0);
    check_eq("t4_rbr_stale", {24'd0, reg_rd_data}, 32'h5A);
    check_eq("t4_pulses", rd_en_pulses - base, 32'd1);

    // Read with nothing held is ignored
    base = rd_en_pulses;
    rd_rbr();
    cyc();
    cyc();
    check_eq("t5_pulses", rd_en_pulses - base, 32'd0);
    check_eq("t5_cnt", {16'd0, rx_byte_count}, exp_cnt(5));
    check_eq("t5_rbr", {24'd0, reg_rd_data}, 32'h5A);

    // Flush and read together: flush wins, byte not counted
    push(8'h3C);
    wait_ready("t5_ready");
    check_eq("t5_rbr_new", {24'd0, reg_rd_data}, 32'h3C);
    flush_req = 1'b1;
    reg_rd_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    reg_rd_req = 1'b0;
    check_eq("t5_busy", {31'd0, flush_busy}, 32'd1);
    check_eq("t5_dr", {31'd0, data_ready}, 32'd0);
    check_eq("t5_cnt_flush", {16'd0, rx_byte_count}, exp_cnt(5));
    for (int i = 0; i < 5; i++) cyc();
    check_eq("t5_idle", {31'd0, flush_busy}, 32'd0);

    // Reset while holding a byte with irq asserted
    ien_avail = 1'b1;
    push(8'h99);
    wait_ready("t6_ready");
    cyc();
    check_eq("t6_irq_pre", {31'd0, irq}, 32'd1);
    rd_rst = 1'b1;
    cyc();
    check_reset_vals("t6");
    rd_rst = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
